// File: rtl/rvb_shifter_issue_if.sv
// Bundle between the issue stage and its neighbours: upstream instruction
// port, downstream port toward rvb_shifter, rejection status and debug state.
interface rvb_shifter_issue_if #(
    parameter int XLEN = 32
);
    // Valid/ready: a beat transfers on a rising edge where valid && ready are both high.
    // A producer holding valid must keep its payload stable until that edge.
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_insn;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_rs3;

    logic            dout_valid;
    logic            dout_ready;
    logic [XLEN-1:0] dout_rs1;
    logic [XLEN-1:0] dout_rs2;
    logic [XLEN-1:0] dout_rs3;
    logic            dout_insn3;
    logic            dout_insn12;
    logic            dout_insn14;
    logic            dout_insn26;
    logic            dout_insn27;
    logic            dout_insn29;
    logic            dout_insn30;

    logic            rej_valid;
    logic [15:0]     rej_count;
    logic [1:0]      occ_dbg;

    modport master (
        output in_valid, in_insn, in_rs1, in_rs2, in_rs3, dout_ready,
        input  in_ready, dout_valid, dout_rs1, dout_rs2, dout_rs3,
        input  dout_insn3, dout_insn12, dout_insn14, dout_insn26,
        input  dout_insn27, dout_insn29, dout_insn30,
        input  rej_valid, rej_count, occ_dbg
    );

    modport slave (
        input  in_valid, in_insn, in_rs1, in_rs2, in_rs3, dout_ready,
        output in_ready, dout_valid, dout_rs1, dout_rs2, dout_rs3,
        output dout_insn3, dout_insn12, dout_insn14, dout_insn26,
        output dout_insn27, dout_insn29, dout_insn30,
        output rej_valid, rej_count, occ_dbg
    );
endinterface

// File: rtl/rvb_shifter_issue.sv
// Issue stage for rvb_shifter: classifies shift instructions, muxes the
// immediate shift amount into rs2 and buffers up to two entries.
module rvb_shifter_issue #(
    parameter int XLEN    = 32,
    parameter int TERNARY = 1
) (
    input logic                clock,
    input logic                resetn,
    rvb_shifter_issue_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    localparam int EW = 3 * XLEN + 7;

    occ_e            occ_q;
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic            rej_valid_q;
    logic [15:0]     rej_count_q;
    logic [EW-1:0]   mem_q [2];

    logic [6:0]      opcode;
    logic            is_shift;
    logic            accept;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] rs2_d;
    logic            insn3_d;
    logic [EW-1:0]   entry_d;
    logic [EW-1:0]   head;
    logic            unused_insn_bits;

    assign opcode = bus.in_insn[6:0];

    always_comb begin
        is_shift = 1'b0;
        if (bus.in_insn[13:12] == 2'b01) begin
            if (opcode == 7'b0110011 || opcode == 7'b0010011)
                is_shift = 1'b1;
            if (XLEN == 64 && (opcode == 7'b0111011 || opcode == 7'b0011011))
                is_shift = 1'b1;
        end
        if (TERNARY == 0 && bus.in_insn[26])
            is_shift = 1'b0;
    end

    // Immediate forms carry the shift amount in the instruction, not in rs2.
    always_comb begin
        rs2_d = bus.in_rs2;
        if (opcode == 7'b0010011) begin
            rs2_d = '0;
            if (XLEN == 64) rs2_d[5:0] = bus.in_insn[25:20];
            else            rs2_d[4:0] = bus.in_insn[24:20];
        end else if (opcode == 7'b0011011) begin
            rs2_d      = '0;
            rs2_d[4:0] = bus.in_insn[24:20];
        end
    end

    assign insn3_d = (XLEN == 64) ? bus.in_insn[3] : 1'b0;
    assign entry_d = {bus.in_rs1, rs2_d, bus.in_rs3, insn3_d,
                      bus.in_insn[12], bus.in_insn[14], bus.in_insn[26],
                      bus.in_insn[27], bus.in_insn[29], bus.in_insn[30]};

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && is_shift;
    assign pop    = bus.dout_valid && bus.dout_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            occ_q       <= EMPTY;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            rej_valid_q <= 1'b0;
            rej_count_q <= 16'h0000;
        end else begin
            case (occ_q)
                EMPTY:   if (push) occ_q <= ONE;
                ONE: begin
                    if (push && !pop)      occ_q <= FULL;
                    else if (!push && pop) occ_q <= EMPTY;
                end
                FULL:    if (pop) occ_q <= ONE;
                default: occ_q <= EMPTY;
            endcase
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            rej_valid_q <= accept && !is_shift;
            if (accept && !is_shift && rej_count_q != 16'hFFFF)
                rej_count_q <= rej_count_q + 16'd1;
        end
    end

    // Payload storage carries no reset; occupancy alone says what is live.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= entry_d;
    end

    assign head = mem_q[rd_ptr_q];

    assign bus.in_ready   = (occ_q != FULL);
    assign bus.dout_valid = (occ_q != EMPTY);
    assign {bus.dout_rs1, bus.dout_rs2, bus.dout_rs3, bus.dout_insn3,
            bus.dout_insn12, bus.dout_insn14, bus.dout_insn26,
            bus.dout_insn27, bus.dout_insn29, bus.dout_insn30} = head;
    assign bus.rej_valid  = rej_valid_q;
    assign bus.rej_count  = rej_count_q;
    assign bus.occ_dbg    = occ_q;

    assign unused_insn_bits = ^{bus.in_insn[31], bus.in_insn[28],
                                bus.in_insn[25], bus.in_insn[19:15],
                                bus.in_insn[11:7]};
endmodule

// File: doc/rvb_shifter_issue.md
RVB_SHIFTER_ISSUE -- requirements
Module: rvb_shifter_issue

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter TERNARY, default 1; 1 = funnel/ternary forms (insn[26]=1) are forwarded, 0 = they are rejected.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  block can accept an instruction this cycle.
REQ-007 in_insn  input  32  full RISC-V instruction word.
REQ-008 in_rs1, in_rs2, in_rs3  input  XLEN each  register operands.
REQ-009 dout_valid  output  1  entry presented to rvb_shifter din_valid.
REQ-010 dout_ready  input  1  rvb_shifter din_ready.
REQ-011 dout_rs1, dout_rs2, dout_rs3  output  XLEN each  operands to shifter.
REQ-012 dout_insn3, dout_insn12, dout_insn14, dout_insn26, dout_insn27, dout_insn29, dout_insn30  output  1 each  decoded instruction bits to shifter.
REQ-013 rej_valid  output  1  one-cycle pulse: accepted instruction was not a shifter op.
REQ-014 rej_count  output  16  saturating count of rejected instructions.

Function
REQ-015 Handshake: transfer on input when in_valid && in_ready; on output when dout_valid && dout_ready.
REQ-016 Classification: shifter op iff funct3 in_insn[13:12]==2'b01 and opcode in_insn[6:0] is 0110011 or 0010011, or (XLEN==64 only) 0111011 or 0011011.
REQ-017 Additional reject: TERNARY==0 and in_insn[26]==1 -> not a shifter op.
REQ-018 Rejected instructions are consumed (in_ready honoured), never enter the queue, and assert rej_valid the following cycle only.
REQ-019 rej_count increments by 1 per rejection; holds at 16'hFFFF.
REQ-020 Operand mux: opcode 0010011 -> stored rs2 = zero-extended in_insn[25:20] (XLEN==64) or in_insn[24:20] (XLEN==32); opcode 0011011 -> zero-extended in_insn[24:20]; otherwise in_rs2.
REQ-021 rs1 and rs3 are stored unmodified.
REQ-022 dout_insn3 = stored insn[3] when XLEN==64, constant 0 when XLEN==32.
REQ-023 Other dout_insnN = stored insn[N].
REQ-024 Queue: 2-entry FIFO of {rs1, rs2-muxed, rs3, 7 insn bits}; occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-025 in_ready = (occupancy != FULL), from registered state only; no combinational path from dout_ready to in_ready.
REQ-026 dout_valid = (occupancy != EMPTY); dout_* driven from head entry register.
REQ-027 Latency: instruction accepted at edge N is visible on dout at the cycle after edge N (1 cycle) when queue was EMPTY.
REQ-028 Transitions: EMPTY+push -> ONE; ONE+push+pop -> ONE (new entry becomes head); ONE+push -> FULL; ONE+pop -> EMPTY; FULL+pop -> ONE.
REQ-029 FULL: no push possible (in_ready=0) even if pop occurs same cycle.
REQ-030 Rejected-op push with simultaneous pop: occupancy decrements only; rejection still counted.
REQ-031 Order preserved; head entry and dout_* stable while dout_valid && !dout_ready.
REQ-032 Pointers wrap modulo 2.

Reset
REQ-033 resetn low asynchronously forces occupancy EMPTY, dout_valid=0, rej_valid=0, rej_count=0, in_ready=1.
REQ-034 Queue data registers need no reset; dout_rs*/dout_insn* are don't-care while dout_valid=0.
REQ-035 Reset mid-operation discards all queued entries; no transfer completes on the edge where resetn is low.

Verification
REQ-036 XLEN=32, push insn 0x40005033 (SRA), rs2=5, dout_ready=1 -> next cycle dout_valid=1, dout_insn30=1, dout_insn14=1, dout_insn12=1, dout_rs2=5.
REQ-037 Push slli-form 0x01F09093 with in_rs2=0xDEADBEEF -> dout_rs2=0x0000001F.
REQ-038 dout_ready=0, push 3 valid ops back-to-back -> in_ready=0 after 2nd acceptance; release dout_ready -> entries emerge in order, none lost or duplicated.
REQ-039 Push ADD 0x00208033 -> rej_valid pulses 1 cycle, rej_count=1, dout_valid stays 0; 65536 rejections -> rej_count=16'hFFFF.
REQ-040 TERNARY=0, push insn with insn[26]=1, opcode 0110011, funct3 001 -> rejected; TERNARY=1 -> forwarded with dout_insn26=1.
REQ-041 FULL queue, drop resetn for 1 cycle mid-stream -> dout_valid=0 and in_ready=1 immediately; next push emerges 1 cycle after acceptance.
